// File: rtl/synth_pkg.sv
// Shared types for the voice synthesis pipeline: pipeline state encoding,
// voice RAM word layout and per-field write masks.
package synth_pkg;

  typedef enum logic [1:0] {
    PIPE_READ    = 2'd0,
    PIPE_COMPUTE = 2'd1,
    PIPE_UPDATE  = 2'd2,
    PIPE_ADVANCE = 2'd3
  } pipe_state_e;

  localparam int WAVE_W = 4;

  // Voice RAM word, MSB first: {wave[WAVE_W-1:0], delta[PHASE_W-1:0], phase[PHASE_W-1:0]}.
  // Mask bit 2 enables the wave field, bit 1 delta, bit 0 phase.
  typedef logic [2:0] field_mask_t;

  localparam field_mask_t MASK_NONE        = 3'b000;
  localparam field_mask_t MASK_PHASE       = 3'b001;
  localparam field_mask_t MASK_DELTA_PHASE = 3'b010;
  localparam field_mask_t MASK_WAVE        = 3'b100;
  localparam field_mask_t MASK_ALL         = 3'b111;

  function automatic int word_w(input int phase_w);
    return WAVE_W + 2 * phase_w;
  endfunction

endpackage

// File: rtl/voice_ram.sv
// Single-port per-voice state RAM: one access per cycle, registered read,
// independent write enables for the phase, delta and wave fields.
module voice_ram
  import synth_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int PHASE_W = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        en,
  input  field_mask_t                 wmask,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [word_w(PHASE_W)-1:0]  wdata,
  output logic [word_w(PHASE_W)-1:0]  rdata
);

  localparam int WORD_W = word_w(PHASE_W);

  logic [PHASE_W-1:0] phase_mem [DEPTH];
  logic [PHASE_W-1:0] delta_mem [DEPTH];
  logic [WAVE_W-1:0]  wave_mem  [DEPTH];

  // NOTE: the storage arrays have no reset; the owner clears them with an INIT
  // sweep, which keeps them mappable onto block RAM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge i_clk) begin
    if (en) begin
      if (wmask[0]) phase_mem[addr] <= wdata[PHASE_W-1:0];
      if (wmask[1]) delta_mem[addr] <= wdata[2*PHASE_W-1:PHASE_W];
      if (wmask[2]) wave_mem[addr]  <= wdata[WORD_W-1 -: WAVE_W];
    end
  end

  // A cycle with no field enabled is a read; rdata holds across write cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdata <= '0;
    end else if (en && (wmask == MASK_NONE)) begin
      rdata <= {wave_mem[addr], delta_mem[addr], phase_mem[addr]};
    end
  end

endmodule

// File: rtl/phase_accumulator.sv
// Time-multiplexed per-voice NCO: walks every voice through a 4-state
// read/compute/update/advance pipeline and applies MIDI pitch updates.
module phase_accumulator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 128,
  parameter int VOICE_W     = 8,
  parameter int PHASE_W     = 32,
  parameter int OUT_PHASE_W = 10
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_update_valid,
  input  logic [VOICE_W-1:0]     i_update_voice,
  input  logic [PHASE_W-1:0]     i_update_delta,
  input  logic [3:0]             i_update_wave,
  input  logic                   i_update_zero_phase,
  output logic                   o_update_ready,
  output logic [OUT_PHASE_W-1:0] o_phase,
  output logic [3:0]             o_wave_select,
  output logic [VOICE_W-1:0]     o_voice_index,
  output logic [1:0]             o_pipeline_state,
  output logic                   o_frame_start
);

  localparam int WORD_W = word_w(PHASE_W);
  localparam int ADDR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VOICE_W-1:0] LAST_VOICE   = VOICE_W'(NUM_VOICES - 1);
  localparam logic [VOICE_W:0]   VOICE_LIMIT  = (VOICE_W + 1)'(NUM_VOICES);

  pipe_state_e         state_q, state_d;
  logic                running_q, running_d;
  logic [VOICE_W-1:0]  voice_q, voice_d;
  logic [VOICE_W-1:0]  init_addr_q, init_addr_d;

  logic                pend_valid_q;
  logic [VOICE_W-1:0]  pend_voice_q;
  logic [PHASE_W-1:0]  pend_delta_q;
  logic [WAVE_W-1:0]   pend_wave_q;
  logic                pend_zero_q;

  logic                update_fire;
  logic                apply_update;

  logic                ram_en;
  field_mask_t         ram_mask;
  logic [ADDR_W-1:0]   ram_addr;
  logic [WORD_W-1:0]   ram_wdata;
  logic [WORD_W-1:0]   ram_rdata;

  logic [PHASE_W-1:0]  rd_phase;
  logic [PHASE_W-1:0]  rd_delta;
  logic [WAVE_W-1:0]   rd_wave;

  assign rd_phase = ram_rdata[PHASE_W-1:0];
  assign rd_delta = ram_rdata[2*PHASE_W-1:PHASE_W];
  assign rd_wave  = ram_rdata[WORD_W-1 -: WAVE_W];

  assign o_update_ready   = running_q && !pend_valid_q;
  assign update_fire      = i_update_valid && o_update_ready;
  assign o_phase          = rd_phase[PHASE_W-1 -: OUT_PHASE_W];
  assign o_wave_select    = rd_wave;
  assign o_voice_index    = voice_q;
  assign o_pipeline_state = state_q;
  assign o_frame_start    = running_q && (state_q == PIPE_READ) && (voice_q == '0);

  voice_ram #(
    .DEPTH   (NUM_VOICES),
    .ADDR_W  (ADDR_W),
    .PHASE_W (PHASE_W)
  ) u_voice_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .en      (ram_en),
    .wmask   (ram_mask),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    running_d    = running_q;
    voice_d      = voice_q;
    init_addr_d  = init_addr_q;
    ram_en       = 1'b0;
    ram_mask     = MASK_NONE;
    ram_addr     = voice_q[ADDR_W-1:0];
    ram_wdata    = '0;
    apply_update = 1'b0;

    if (!running_q) begin
      // INIT sweep: zero one voice per cycle while the state stays at ADVANCE.
      ram_en   = 1'b1;
      ram_mask = MASK_ALL;
      ram_addr = init_addr_q[ADDR_W-1:0];
      if (init_addr_q == LAST_VOICE) begin
        running_d = 1'b1;
        state_d   = PIPE_READ;
        voice_d   = '0;
      end else begin
        init_addr_d = init_addr_q + 1'b1;
      end
    end else begin
      case (state_q)
        PIPE_READ: begin
          ram_en  = 1'b1;
          state_d = PIPE_COMPUTE;
        end
        PIPE_COMPUTE: begin
          ram_en    = 1'b1;
          ram_mask  = MASK_PHASE;
          ram_wdata = {WAVE_W'(0), PHASE_W'(0), rd_phase + rd_delta};
          state_d   = PIPE_UPDATE;
        end
        PIPE_UPDATE: begin
          // An out-of-range voice is consumed here without touching the RAM.
          apply_update = pend_valid_q;
          if (pend_valid_q && ({1'b0, pend_voice_q} < VOICE_LIMIT)) begin
            ram_en    = 1'b1;
            ram_addr  = pend_voice_q[ADDR_W-1:0];
            ram_mask  = MASK_DELTA_PHASE | MASK_WAVE | (pend_zero_q ? MASK_PHASE : MASK_NONE);
            ram_wdata = {pend_wave_q, pend_delta_q, PHASE_W'(0)};
          end
          state_d = PIPE_ADVANCE;
        end
        PIPE_ADVANCE: begin
          voice_d = (voice_q == LAST_VOICE) ? '0 : voice_q + 1'b1;
          state_d = PIPE_READ;
        end
        default: state_d = PIPE_READ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= PIPE_ADVANCE;
      running_q   <= 1'b0;
      voice_q     <= '0;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      voice_q     <= voice_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Ready is low whenever an update is pending, so capture and apply never coincide.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_valid_q <= 1'b0;
      pend_voice_q <= '0;
      pend_delta_q <= '0;
      pend_wave_q  <= '0;
      pend_zero_q  <= 1'b0;
    end else if (update_fire) begin
      pend_valid_q <= 1'b1;
      pend_voice_q <= i_update_voice;
      pend_delta_q <= i_update_delta;
      pend_wave_q  <= i_update_wave;
      pend_zero_q  <= i_update_zero_phase;
    end else if (apply_update) begin
      pend_valid_q <= 1'b0;
    end
  end

endmodule
